// File: rtl/cnn_pkg.sv
// Shared types and constants for the CNN output write-back path.
// Holds the scheduler state encoding and the buffer address width.
package cnn_pkg;

  localparam int BUF_AW = 14;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BURST  = 2'b01,
    NEXT   = 2'b10,
    FINISH = 2'b11
  } state_e;

endpackage

// File: rtl/output_writeback_scheduler_if.sv
// Bundle between layer controller / output FIFOs / output buffer
// and the write-back scheduler.
interface output_writeback_scheduler_if #(
  parameter int NUM_CH       = 4,
  parameter int dimdata_size = 16,
  parameter int DATA_W       = 16,
  parameter int CH_W         = $clog2(NUM_CH) + 1
);
  import cnn_pkg::*;

  logic                     start;
  logic [BUF_AW-1:0]        base_address;
  logic [dimdata_size-1:0]  output_featuremapsize;
  logic [CH_W-1:0]          num_channels;
  logic [NUM_CH-1:0]        fifo_empty;
  logic [NUM_CH*DATA_W-1:0] fifo_data;
  logic [NUM_CH-1:0]        fifo_rd_en;
  logic [BUF_AW-1:0]        buf_address;
  logic [DATA_W-1:0]        buf_data;
  logic                     write_enable;
  logic [CH_W-1:0]          ch_index;
  logic                     busy;
  logic                     done;

  modport slave (
    input  start, base_address, output_featuremapsize,
    input  num_channels, fifo_empty, fifo_data,
    output fifo_rd_en, buf_address, buf_data,
    output write_enable, ch_index, busy, done
  );

  modport master (
    output start, base_address, output_featuremapsize,
    output num_channels, fifo_empty, fifo_data,
    input  fifo_rd_en, buf_address, buf_data,
    input  write_enable, ch_index, busy, done
  );

endinterface

// File: rtl/burst_addr_gen.sv
// Per-channel region base and word counter for write-back.
// Produces the current buffer address and a last-word flag.
module burst_addr_gen
  import cnn_pkg::*;
#(
  parameter int dimdata_size = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic                    advance,
  input  logic                    step,
  input  logic [BUF_AW-1:0]       base_in,
  input  logic [dimdata_size-1:0] fsize_in,
  output logic [BUF_AW-1:0]       addr,
  output logic                    last
);

  localparam logic [dimdata_size-1:0] ONE = 1;

  logic [BUF_AW-1:0]       ch_base_q, ch_base_d;
  logic [dimdata_size-1:0] count_q, count_d;
  logic [dimdata_size-1:0] fsize_q, fsize_d;

  assign addr = ch_base_q + BUF_AW'(count_q);
  assign last = (count_q == fsize_q - ONE);

  // load restarts at channel 0, advance moves to the next region
  always_comb begin
    ch_base_d = ch_base_q;
    count_d   = count_q;
    fsize_d   = fsize_q;
    if (load) begin
      ch_base_d = base_in;
      count_d   = '0;
      fsize_d   = fsize_in;
    end else if (advance) begin
      ch_base_d = ch_base_q + BUF_AW'(fsize_q);
      count_d   = '0;
    end else if (step) begin
      count_d = count_q + ONE;
    end
  end

  // counter state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ch_base_q <= '0;
      count_q   <= '0;
      fsize_q   <= '0;
    end else begin
      ch_base_q <= ch_base_d;
      count_q   <= count_d;
      fsize_q   <= fsize_d;
    end
  end

endmodule

// File: rtl/output_writeback_scheduler.sv
// Drains per-channel output FIFOs into consecutive buffer regions,
// channel by channel, with one done pulse per layer.
module output_writeback_scheduler
  import cnn_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int dimdata_size = 16,
  parameter int DATA_W       = 16,
  parameter int CH_W         = $clog2(NUM_CH) + 1
) (
  input  logic                         w_clk,
  input  logic                         reset,
  output_writeback_scheduler_if.slave  bus
);

  state_e             state_q, state_d;
  logic [CH_W-1:0]    ch_q, ch_d;
  logic [CH_W-1:0]    ncnt_q, ncnt_d;
  logic               we_q, we_d;
  logic [BUF_AW-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               done_q, done_d;

  logic               sel_empty;
  logic [DATA_W-1:0]  sel_data;
  logic               pop;
  logic [NUM_CH-1:0]  rd_en;
  logic               load, advance;
  logic [BUF_AW-1:0]  gen_addr;
  logic               gen_last;

  burst_addr_gen #(
    .dimdata_size(dimdata_size)
  ) u_addr (
    .clk     (w_clk),
    .rst     (reset),
    .load    (load),
    .advance (advance),
    .step    (pop),
    .base_in (bus.base_address),
    .fsize_in(bus.output_featuremapsize),
    .addr    (gen_addr),
    .last    (gen_last)
  );

  // channel mux and one-hot pop demux
  always_comb begin
    sel_empty = 1'b1;
    sel_data  = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (ch_q == CH_W'(k)) begin
        sel_empty = bus.fifo_empty[k];
        sel_data  = bus.fifo_data[k*DATA_W +: DATA_W];
      end
    end
    pop = (state_q == BURST) && !sel_empty;
    for (int k = 0; k < NUM_CH; k++) begin
      rd_en[k] = pop && (ch_q == CH_W'(k)) && !reset;
    end
  end

  // sequencing of channels and write strobe generation
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    ncnt_d  = ncnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    we_d    = 1'b0;
    load    = 1'b0;
    advance = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          load   = 1'b1;
          ch_d   = '0;
          ncnt_d = bus.num_channels;
          if (bus.num_channels == '0 ||
              bus.output_featuremapsize == '0)
            state_d = FINISH;
          else
            state_d = BURST;
        end
      end
      BURST: begin
        if (pop) begin
          we_d   = 1'b1;
          addr_d = gen_addr;
          data_d = sel_data;
          if (gen_last) state_d = NEXT;
        end
      end
      NEXT: begin
        if (ch_q == ncnt_q - CH_W'(1)) begin
          state_d = FINISH;
        end else begin
          ch_d    = ch_q + CH_W'(1);
          advance = 1'b1;
          state_d = BURST;
        end
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    done_d = (state_d == FINISH);
  end

  // state and registered outputs
  always_ff @(posedge w_clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ch_q    <= '0;
      ncnt_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      ncnt_q  <= ncnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
  end

  assign bus.fifo_rd_en   = rd_en;
  assign bus.buf_address  = addr_q;
  assign bus.buf_data     = data_q;
  assign bus.write_enable = we_q;
  assign bus.ch_index     = ch_q;
  assign bus.busy         = (state_q != IDLE);
  assign bus.done         = done_q;

endmodule

// File: tb/tb_output_writeback_scheduler.sv
// Randomized bench for output_writeback_scheduler.
// Reference: expected writes as base + ch*F + i over FIFO contents.
module tb_output_writeback_scheduler;

  localparam int NUM_CH = 4;
  localparam int FW     = 16;
  localparam int DW     = 16;
  localparam int CW     = $clog2(NUM_CH) + 1;

  logic w_clk = 1'b0;
  logic reset;

  always #5 w_clk = ~w_clk;

  output_writeback_scheduler_if #(
    .NUM_CH(NUM_CH), .dimdata_size(FW),
    .DATA_W(DW), .CH_W(CW)
  ) bus ();

  output_writeback_scheduler #(
    .NUM_CH(NUM_CH), .dimdata_size(FW),
    .DATA_W(DW), .CH_W(CW)
  ) dut (
    .w_clk(w_clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic [13:0] a;
    logic [15:0] d;
    int          ch;
  } wr_t;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] fq [NUM_CH][$];
  wr_t exp_pop[$];
  wr_t exp_wr[$];

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit stalled);
    for (int k = 0; k < NUM_CH; k++) begin
      bus.fifo_empty[k] = (fq[k].size() == 0) ||
                          (stalled && k == 1);
      bus.fifo_data[k*DW +: DW] =
        (fq[k].size() != 0) ? fq[k][0] : '0;
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_we"},   32'(bus.write_enable), 0);
    chk({tag, "_addr"}, 32'(bus.buf_address), 0);
    chk({tag, "_data"}, 32'(bus.buf_data), 0);
    chk({tag, "_ch"},   32'(bus.ch_index), 0);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
    chk({tag, "_done"}, 32'(bus.done), 0);
    chk({tag, "_rd"},   32'(bus.fifo_rd_en), 0);
  endtask

  // one layer: base, F, C, stall on ch1 after its 2nd pop,
  // cycle of an ignored start (0 = none), write index to reset at
  task automatic run_layer(input logic [13:0] base,
                           input int f, input int c,
                           input int stall, input int ign,
                           input int rst_wr);
    int exp_done, wcnt, ndone, pops1, s_from, s_to;
    wr_t w;
    logic [3:0] rd, msk;
    for (int k = 0; k < NUM_CH; k++) begin
      fq[k].delete();
      for (int i = 0; i < f + 2; i++)
        fq[k].push_back(16'($urandom));
    end
    exp_pop.delete();
    exp_wr.delete();
    for (int ch = 0; ch < c; ch++)
      for (int i = 0; i < f; i++) begin
        w.a  = base + 14'(ch * f + i);
        w.d  = fq[ch][i];
        w.ch = ch;
        exp_pop.push_back(w);
      end
    exp_done = (c == 0 || f == 0) ? 1 : c * (f + 1) + 1 + stall;
    s_from = -1;
    s_to   = -1;
    wcnt   = 0;
    ndone  = 0;
    pops1  = 0;
    @(negedge w_clk);
    bus.start                 = 1'b1;
    bus.base_address          = base;
    bus.output_featuremapsize = 16'(f);
    bus.num_channels          = 3'(c);
    drive(1'b0);
    for (int cyc = 1; cyc <= exp_done; cyc++) begin
      @(negedge w_clk);
      bus.start = (cyc == ign);
      if (cyc == ign) bus.base_address = ~base;
      if (bus.write_enable) begin
        if (exp_wr.size() == 0) begin
          chk("spurious_we", 1, 0);
        end else begin
          w = exp_wr.pop_front();
          chk("wr_addr", 32'(bus.buf_address), 32'(w.a));
          chk("wr_data", 32'(bus.buf_data), 32'(w.d));
          chk("wr_ch", 32'(bus.ch_index), 32'(w.ch));
        end
        wcnt++;
      end
      chk("done", 32'(bus.done), 32'(cyc == exp_done));
      chk("busy", 32'(bus.busy), 1);
      ndone += int'(bus.done);
      if (bus.write_enable && wcnt == rst_wr) begin
        #1 reset = 1'b1;
        #1 chk_zero("rst_mid");
        @(negedge w_clk);
        chk_zero("rst_hold");
        reset = 1'b0;
        return;
      end
      drive(cyc >= s_from && cyc <= s_to);
      #1;
      rd  = bus.fifo_rd_en;
      msk = (exp_pop.size() != 0) ? 4'(1 << exp_pop[0].ch) : 4'h0;
      chk("rd_en_chan", 32'(rd & ~msk), 0);
      if (rd != 0) begin
        chk("rd_on_empty", 32'(rd & bus.fifo_empty), 0);
        if (exp_pop.size() != 0) begin
          w = exp_pop.pop_front();
          exp_wr.push_back(w);
          void'(fq[w.ch].pop_front());
          if (w.ch == 1) begin
            pops1++;
            if (pops1 == 2 && stall > 0) begin
              s_from = cyc + 1;
              s_to   = cyc + stall;
            end
          end
        end
      end
    end
    chk("n_writes", 32'(wcnt), 32'(c * f));
    chk("done_count", 32'(ndone), 1);
  endtask

  initial begin
    int f, c, st;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.base_address = '0;
    bus.output_featuremapsize = '0;
    bus.num_channels = '0;
    for (int k = 0; k < NUM_CH; k++) fq[k].delete();
    drive(1'b0);
    @(negedge w_clk);
    @(negedge w_clk);
    chk_zero("reset");
    reset = 1'b0;

    run_layer(14'h0100, 4, 3, 0, 5, -1);
    run_layer(14'h0100, 4, 3, 5, 0, -1);
    run_layer(14'h3FFE, 4, 1, 0, 0, -1);
    run_layer(14'h0123, 0, 3, 0, 0, -1);
    run_layer(14'h0123, 4, 0, 0, 0, -1);
    run_layer(14'h0200, 4, 3, 0, 0, 4 + 3);
    run_layer(14'h0555, 4, 3, 0, 0, -1);
    run_layer(14'h0040, 3, 2, 0, 0, -1);
    for (int r = 0; r < 8; r++) begin
      f  = $urandom_range(1, 6);
      c  = $urandom_range(1, 4);
      st = (c >= 2 && f >= 3) ? $urandom_range(0, 4) : 0;
      run_layer(14'($urandom), f, c, st, 0, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
